// File: rtl/sumador_multipalabra_pkg.sv
// Shared constants for the multi-word adder sequencer: FSM state codes and
// a helper that sizes the word index register.
package sumador_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUMA = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // A single-word configuration still needs a 1-bit index register.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sumador_multipalabra_sumador.sv
// N-bit combinational adder with carry-in, carry-out and signed overflow.
module sumador #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         V
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
  assign V = (A[N-1] == B[N-1]) && (S[N-1] != A[N-1]);

endmodule

// File: rtl/sumador_multipalabra.sv
// Adds two M*N-bit operands LSB word first over M cycles through one shared sumador.
// Optional subtraction mode (extra 'op' port) when SUMADOR_MULTIPALABRA_RESTA_EN is defined.
module sumador_multipalabra
  import sumador_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
`ifdef SUMADOR_MULTIPALABRA_RESTA_EN
  input  logic           op,
`endif
  input  logic           start,
  input  logic [N*M-1:0] A,
  input  logic [N*M-1:0] B,
  input  logic           Cin,
  output logic           busy,
  output logic           done,
  output logic [N*M-1:0] S,
  output logic           Cout,
  output logic           V
);

  localparam int W  = N * M;
  localparam int KW = idx_width(M);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, b_q, s_q;
  logic [KW-1:0] k_q;
  logic          c_q, cout_q, v_q;
  logic          op_q;
  logic          last_word;

  logic [N-1:0]  word_a, word_b, word_b_raw, word_sum;
  logic          word_cout, word_v;

  assign word_a     = a_q[k_q*N +: N];
  assign word_b_raw = b_q[k_q*N +: N];
  assign word_b     = op_q ? ~word_b_raw : word_b_raw;
  assign last_word  = (k_q == KW'(M - 1));

  sumador #(.N(N)) u_sumador (
    .A    (word_a),
    .B    (word_b),
    .Cin  (c_q),
    .S    (word_sum),
    .Cout (word_cout),
    .V    (word_v)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SUMA;
      SUMA:    if (last_word) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q <= A;
            b_q <= B;
            k_q <= '0;
`ifdef SUMADOR_MULTIPALABRA_RESTA_EN
            op_q <= op;
            // Subtraction is A + ~B + 1, so the caller's Cin is overridden.
            c_q  <= op ? 1'b1 : Cin;
`else
            op_q <= 1'b0;
            c_q  <= Cin;
`endif
          end
        end
        SUMA: begin
          s_q[k_q*N +: N] <= word_sum;
          c_q             <= word_cout;
          if (last_word) begin
            cout_q <= word_cout;
            v_q    <= word_v;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == SUMA) || (state_q == FIN);
  assign done = (state_q == FIN);
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_sumador_multipalabra.sv
// Self-checking bench for sumador_multipalabra (N=8, M=4): arithmetic/latency
// model checked every cycle, plus directed vectors with literal results.
module tb_sumador_multipalabra;

  localparam int N = 8;
  localparam int M = 4;
  localparam int W = N * M;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         Cin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Cout, V;
  logic [W-1:0] S;

  int vectors = 0;
  int miscompares = 0;

  sumador_multipalabra #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SUMADOR_MULTIPALABRA_RESTA_EN
    .op    (op),
`endif
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles remaining until idle, and the expected wide result.
  int           cnt = 0;
  logic [W-1:0] m_s = '0;
  logic         m_c = 1'b0;
  logic         m_v = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W:0]   t;
    logic [W-1:0] bb;
    logic         ci;
    if (rst) begin
      cnt = 0;
      m_s = '0;
      m_c = 1'b0;
      m_v = 1'b0;
    end else if (cnt == 0) begin
      if (start) begin
`ifdef SUMADOR_MULTIPALABRA_RESTA_EN
        bb = op ? ~B : B;
        ci = op ? 1'b1 : Cin;
`else
        bb = B;
        ci = Cin;
`endif
        t   = {1'b0, A} + {1'b0, bb} + {{W{1'b0}}, ci};
        m_s = t[W-1:0];
        m_c = t[W];
        m_v = (A[W-1] == bb[W-1]) && (m_s[W-1] != A[W-1]);
        cnt = M + 1;
      end
    end else begin
      cnt = cnt - 1;
    end
  end

  always @(negedge clk) begin
    check("busy", W'(busy), W'(cnt > 0));
    check("done", W'(done), W'(cnt == 1));
    if (cnt <= 1) begin
      check("S", S, m_s);
      check("Cout", W'(Cout), W'(m_c));
      check("V", W'(V), W'(m_v));
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic o, input logic [W-1:0] es, input logic ec, input logic ev);
    int n;
    int bc;
    @(negedge clk);
    A = a; B = b; Cin = ci; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bc = 0;
    while (n < 20) begin
      if (busy) bc++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, required done within 20 cycles");
    end else begin
      check("lit_S", S, es);
      check("lit_Cout", W'(Cout), W'(ec));
      check("lit_V", W'(V), W'(ev));
      check("busy_cycles", W'(bc), W'(M + 1));
      @(negedge clk);
      check("done_single", W'(done), '0);
      check("busy_after", W'(busy), '0);
      check("S_hold", S, es);
    end
  endtask

  initial begin
    int pulses;
    logic [W-1:0] s_at_done;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_S", S, '0);
    rst = 1'b0;

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);

    // start while busy must be ignored
    @(negedge clk);
    A = 32'd1000; B = 32'd2000; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    s_at_done = '0;
    repeat (10) begin
      if (done) begin
        pulses++;
        s_at_done = S;
      end
      @(negedge clk);
    end
    check("ignored_pulses", W'(pulses), W'(1));
    check("ignored_S", s_at_done, 32'd3000);

    // reset in the middle of an operation
    @(negedge clk);
    A = 32'h12345678; B = 32'h11111111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_S", S, '0);
    check("midrst_Cout", W'(Cout), '0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

`ifdef SUMADOR_MULTIPALABRA_RESTA_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op(32'h80000000, 32'd1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op(32'd10, 32'd3, 1'b0, 1'b0, 32'd13, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
